// File: rtl/coder_axil_slave.sv
`default_nettype none
// ============================================================================
// Module  : coder_axil_slave
// Brief   : AXI4-Lite register block - 4 RW control regs, write/read counters, ID.
// Revision: 1.0
// ============================================================================
module coder_axil_slave #(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] ID_VALUE           = 32'hC0DE0100
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   ctrl_regs
);

  localparam int         c_DW          = C_S_AXI_DATA_WIDTH;
  localparam int         c_STRB_W      = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  logic                   aw_held_q, aw_held_d;
  logic [2:0]             awslot_q, awslot_d;
  logic                   w_held_q, w_held_d;
  logic [c_DW-1:0]        wdata_q, wdata_d;
  logic [c_STRB_W-1:0]    wstrb_q, wstrb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [c_DW-1:0]        rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [3:0][c_DW-1:0]   regs_q, regs_d;
  logic [31:0]            wr_count_q, wr_count_d;
  logic [31:0]            rd_count_q, rd_count_d;

  logic                   w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [2:0]             w_wr_slot;
  logic [c_DW-1:0]        w_wr_data;
  logic [c_STRB_W-1:0]    w_wr_strb;
  logic [2:0]             w_rd_slot;
  logic                   unused_ok;

  assign S_AXI_AWREADY = !S_AXI_ARESET && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !S_AXI_ARESET && !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = !S_AXI_ARESET && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl_regs     = regs_q;

  assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_commit = (aw_held_q || w_aw_hs) && (w_held_q || w_w_hs);

  // A held beat takes precedence; otherwise the beat handshaking this cycle is used.
  assign w_wr_slot = aw_held_q ? awslot_q : S_AXI_AWADDR[4:2];
  assign w_wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
  assign w_wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;
  assign w_rd_slot = S_AXI_ARADDR[4:2];

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    aw_held_d  = aw_held_q;
    awslot_d   = awslot_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_count_d = wr_count_q;

    if (w_aw_hs) begin
      aw_held_d = 1'b1;
      awslot_d  = S_AXI_AWADDR[4:2];
    end
    if (w_w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (w_commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (!w_wr_slot[2]) begin
        for (int k = 0; k < c_STRB_W; k++) begin
          if (w_wr_strb[k]) begin
            regs_d[w_wr_slot[1:0]][8*k +: 8] = w_wr_data[8*k +: 8];
          end
        end
        wr_count_d = wr_count_q + 32'd1;
        bresp_d    = c_RESP_OKAY;
      end else begin
        bresp_d = c_RESP_SLVERR;
      end
    end
  end

  // Reads sample the pre-edge state, so same-cycle commits are not yet visible.
  always_comb begin
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_count_d = rd_count_q;

    if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    if (w_ar_hs) begin
      rvalid_d   = 1'b1;
      rresp_d    = c_RESP_OKAY;
      rd_count_d = rd_count_q + 32'd1;
      case (w_rd_slot)
        3'd0, 3'd1, 3'd2, 3'd3: rdata_d = regs_q[w_rd_slot[1:0]];
        3'd4:                   rdata_d = wr_count_q;
        3'd5:                   rdata_d = rd_count_q;
        3'd6:                   rdata_d = ID_VALUE;
        default: begin
          rdata_d    = '0;
          rresp_d    = c_RESP_SLVERR;
          rd_count_d = rd_count_q;
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_held_q  <= 1'b0;
      awslot_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      regs_q     <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      awslot_q   <= awslot_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coder_axil_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_coder_axil_slave
// Brief   : Self-checking bench for coder_axil_slave (vector table + scoreboard).
// Revision: 1.0
// ============================================================================
module tb_coder_axil_slave;

  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_SLVERR = 2'b10;
  localparam int         c_BOUND  = 50;

  logic         clk;
  logic         rst;
  logic [4:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [4:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] ctrl_regs;

  coder_axil_slave dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .ctrl_regs    (ctrl_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  vec_t       tbl [22];
  rexp_t      r_q [$];
  logic [1:0] b_q [$];
  int         n_vec  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles at %0t", name, c_BOUND, $time);
  endtask

  // Response monitor: pops the oldest expectation on each completed handshake.
  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (r_q.size() == 0) begin
        check("unexpected R beat", {96'd0, rdata}, 128'hFFFF_FFFF);
      end else begin
        rexp_t e;
        e = r_q.pop_front();
        check($sformatf("RDATA @%h", e.addr), {96'd0, rdata}, {96'd0, e.data});
        check($sformatf("RRESP @%h", e.addr), {126'd0, rresp}, {126'd0, e.resp});
      end
    end
    if (bvalid && bready) begin
      if (b_q.size() == 0) begin
        check("unexpected B beat", {126'd0, bresp}, 128'h3_0000);
      end else begin
        logic [1:0] eb;
        eb = b_q.pop_front();
        check("BRESP", {126'd0, bresp}, {126'd0, eb});
      end
    end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input bit wait_b);
    bit aw_done = 0;
    bit w_done  = 0;
    int n       = 0;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    b_q.push_back(er);
    while (!(aw_done && w_done) && n < c_BOUND) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      n++;
    end
    if (!(aw_done && w_done)) begin
      timeout("AW/W handshake");
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    if (wait_b) begin
      n = 0;
      while (b_q.size() != 0 && n < c_BOUND) begin
        @(posedge clk); #1;
        n++;
      end
      if (b_q.size() != 0) begin
        timeout("B response");
        b_q.delete();
      end
    end
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit ar_done = 0;
    int n       = 0;
    rexp_t e;
    e.addr  = a;
    e.data  = ed;
    e.resp  = er;
    araddr  = a;
    arvalid = 1'b1;
    r_q.push_back(e);
    while (!ar_done && n < c_BOUND) begin
      @(negedge clk);
      if (arvalid && arready) ar_done = 1;
      @(posedge clk); #1;
      if (ar_done) arvalid = 1'b0;
      n++;
    end
    if (!ar_done) begin
      timeout("AR handshake");
      arvalid = 1'b0;
    end
    n = 0;
    while (r_q.size() != 0 && n < c_BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    if (r_q.size() != 0) begin
      timeout("R response");
      r_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, 1 expected 0");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 5'h00, 32'h1,        4'hF, 32'h0,        c_OKAY};
    tbl[1]  = '{1'b1, 5'h04, 32'h2,        4'hF, 32'h0,        c_OKAY};
    tbl[2]  = '{1'b1, 5'h08, 32'h3,        4'hF, 32'h0,        c_OKAY};
    tbl[3]  = '{1'b1, 5'h0C, 32'h4,        4'hF, 32'h0,        c_OKAY};
    tbl[4]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h1,        c_OKAY};
    tbl[5]  = '{1'b0, 5'h04, 32'h0,        4'h0, 32'h2,        c_OKAY};
    tbl[6]  = '{1'b0, 5'h08, 32'h0,        4'h0, 32'h3,        c_OKAY};
    tbl[7]  = '{1'b0, 5'h0C, 32'h0,        4'h0, 32'h4,        c_OKAY};
    tbl[8]  = '{1'b0, 5'h14, 32'h0,        4'h0, 32'h4,        c_OKAY};
    tbl[9]  = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h4,        c_OKAY};
    tbl[10] = '{1'b1, 5'h10, 32'h12345678, 4'hF, 32'h0,        c_SLVERR};
    tbl[11] = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h4,        c_OKAY};
    tbl[12] = '{1'b0, 5'h1C, 32'h0,        4'h0, 32'h0,        c_SLVERR};
    tbl[13] = '{1'b0, 5'h18, 32'h0,        4'h0, 32'hC0DE0100, c_OKAY};
    tbl[14] = '{1'b0, 5'h14, 32'h0,        4'h0, 32'h8,        c_OKAY};
    tbl[15] = '{1'b1, 5'h00, 32'hAABBCCDD, 4'h2, 32'h0,        c_OKAY};
    tbl[16] = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h0000CC01, c_OKAY};
    tbl[17] = '{1'b1, 5'h0C, 32'hFFFFFFFF, 4'h0, 32'h0,        c_OKAY};
    tbl[18] = '{1'b0, 5'h0C, 32'h0,        4'h0, 32'h4,        c_OKAY};
    tbl[19] = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h6,        c_OKAY};
    tbl[20] = '{1'b1, 5'h09, 32'h77,       4'hF, 32'h0,        c_OKAY};
    tbl[21] = '{1'b0, 5'h0A, 32'h0,        4'h0, 32'h77,       c_OKAY};

    rst = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

    #100;
    check("reset AWREADY", {127'd0, awready}, 128'd0);
    check("reset WREADY",  {127'd0, wready},  128'd0);
    check("reset ARREADY", {127'd0, arready}, 128'd0);
    check("reset BVALID",  {127'd0, bvalid},  128'd0);
    check("reset RVALID",  {127'd0, rvalid},  128'd0);
    check("reset RDATA",   {96'd0, rdata},    128'd0);
    check("reset ctrl_regs", ctrl_regs,       128'd0);
    #100;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle AWREADY", {127'd0, awready}, 128'd1);
    check("idle ARREADY", {127'd0, arready}, 128'd1);

    for (int i = 0; i < 22; i++) begin
      if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp_resp, 1'b1);
      else           axi_read(tbl[i].addr, tbl[i].exp_data, tbl[i].exp_resp);
      if (i == 3)
        check("ctrl_regs after 4 writes", ctrl_regs,
              128'h00000004_00000003_00000002_00000001);
    end
    check("ctrl_regs after table", ctrl_regs, 128'h00000004_00000077_00000002_0000CC01);

    // W leads AW by 3 cycles, then B stalls 5 cycles with fresh AW/W offered.
    bready = 1'b0;
    @(posedge clk); #1;
    wdata = 32'hDEAD0003; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("WREADY after W hs", {127'd0, wready}, 128'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("WREADY while W held", {127'd0, wready}, 128'd0);
      check("BVALID before AW",    {127'd0, bvalid}, 128'd0);
    end
    check("REG3 before AW", {96'd0, ctrl_regs[127:96]}, 128'h4);
    awaddr = 5'h0C; awvalid = 1'b1;
    b_q.push_back(c_OKAY);
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("REG3 at commit", {96'd0, ctrl_regs[127:96]}, 128'hDEAD0003);
    awaddr = 5'h0C; awvalid = 1'b1; wdata = 32'hBAD0BAD0; wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("BVALID stall", {127'd0, bvalid}, 128'd1);
      check("BRESP stall",  {126'd0, bresp},  128'd0);
      check("AWREADY stall", {127'd0, awready}, 128'd0);
      check("WREADY stall",  {127'd0, wready},  128'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    check("BVALID after B hs", {127'd0, bvalid}, 128'd0);
    check("REG3 single update", {96'd0, ctrl_regs[127:96]}, 128'hDEAD0003);
    check("B queue drained", {96'd0, 32'(b_q.size())}, 128'd0);
    axi_read(5'h10, 32'h8, c_OKAY);
    axi_read(5'h0C, 32'hDEAD0003, c_OKAY);

    // Same-cycle commit and AR: reads see pre-commit state.
    axi_write(5'h04, 32'h5, 4'hF, c_OKAY, 1'b1);
    fork
      axi_write(5'h04, 32'h9, 4'hF, c_OKAY, 1'b1);
      axi_read(5'h04, 32'h5, c_OKAY);
    join
    axi_read(5'h04, 32'h9, c_OKAY);
    fork
      axi_write(5'h08, 32'h33, 4'hF, c_OKAY, 1'b1);
      axi_read(5'h10, 32'd10, c_OKAY);
    join
    axi_read(5'h10, 32'd11, c_OKAY);

    // Reset while a B response is pending.
    bready = 1'b0;
    axi_write(5'h00, 32'h55, 4'hF, c_OKAY, 1'b0);
    check("BVALID pending", {127'd0, bvalid}, 128'd1);
    check("REG0 committed", {96'd0, ctrl_regs[31:0]}, 128'h55);
    rst = 1'b1;
    #1;
    check("BVALID on async reset", {127'd0, bvalid}, 128'd0);
    check("ctrl_regs on async reset", ctrl_regs, 128'd0);
    check("AWREADY in reset", {127'd0, awready}, 128'd0);
    b_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    check("AWREADY after reset", {127'd0, awready}, 128'd1);
    axi_read(5'h00, 32'h0, c_OKAY);
    axi_read(5'h10, 32'h0, c_OKAY);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
